// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int WIDTH = 12;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared by the multiplier and divider datapaths.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/ripple_sub_12.sv
// 12-bit ripple subtractor a - b: full-adder chain on ~b with carry-in 1.
module ripple_sub_12
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    full_adder u_fa (
      .i_a (i_a[g]),
      .i_b (~i_b[g]),
      .i_c (w_carry[g]),
      .o_s (o_diff[g]),
      .o_c (w_carry[g+1])
    );
  end

  // A missing final carry means a < b.
  assign o_borrow = ~w_carry[WIDTH];

endmodule

// File: rtl/seq_divider_12.sv
// Restoring divider, one quotient bit per clock, start/done handshake.
// Handshake: start is accepted on any edge where busy=0; done pulses for one cycle with the result.
module seq_divider_12
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff_lo;
  logic             w_borrow_lo;
  logic             w_borrow;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_shift = {r_r, r_q[WIDTH-1]};

  ripple_sub_12 u_sub (
    .i_a      (w_shift[WIDTH-1:0]),
    .i_b      (r_d),
    .o_diff   (w_diff_lo),
    .o_borrow (w_borrow_lo)
  );

  // 13th bit of the trial subtraction: borrow only if the shifted MSB cannot absorb it.
  assign w_borrow = ~w_shift[WIDTH] & w_borrow_lo;
  assign w_r_next = w_borrow ? w_shift[WIDTH-1:0] : w_diff_lo;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_d     <= i2;
            r_q     <= i1;
            r_r     <= '0;
            r_count <= '0;
            if (i2 != '0) begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_quot  <= DIV0_QUOTIENT;
              r_rem   <= i1;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_q     <= w_q_next;
          r_r     <= w_r_next;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_rem   <= w_r_next;
            r_dz    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Quotient    = r_quot;
  assign Remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dz;

endmodule
